// File: rtl/leiwand_rv32_wb_arbiter.sv
// Two-master round-robin arbiter for the pipelined Wishbone bus.
// Holds grant per cyc burst, caps outstanding requests, aborts on timeout.
module leiwand_rv32_wb_arbiter #(
  parameter int MEM_WIDTH       = 32,
  parameter int SIZE_WIDTH      = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [MEM_WIDTH-1:0]  m0_addr,
  input  logic [MEM_WIDTH-1:0]  m0_data_w,
  input  logic [SIZE_WIDTH-1:0] m0_size,
  output logic [MEM_WIDTH-1:0]  m0_data_r,
  output logic                  m0_ack,
  output logic                  m0_stall,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [MEM_WIDTH-1:0]  m1_addr,
  input  logic [MEM_WIDTH-1:0]  m1_data_w,
  input  logic [SIZE_WIDTH-1:0] m1_size,
  output logic [MEM_WIDTH-1:0]  m1_data_r,
  output logic                  m1_ack,
  output logic                  m1_stall,
  output logic                  m1_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [MEM_WIDTH-1:0]  s_addr,
  output logic [MEM_WIDTH-1:0]  s_data_w,
  output logic [SIZE_WIDTH-1:0] s_size,
  input  logic [MEM_WIDTH-1:0]  s_data_r,
  input  logic                  s_ack,
  input  logic                  s_stall,
  output logic [1:0]            grant
);

  localparam logic [2:0] MAXO = 3'(MAX_OUTSTANDING);
  localparam logic [7:0] TMO  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [2:0] outst_q, outst_d;
  logic [7:0] tmo_q, tmo_d;
  logic [1:0] grant_q;
  logic [1:0] err_q;

  logic       own0, own1;
  logic       full;
  logic       own_cyc, oth_cyc;
  logic       acc, ret;
  logic [7:0] tmo_nx;

  assign own0 = (state_q == GNT0);
  assign own1 = (state_q == GNT1);
  assign full = (outst_q == MAXO);

  assign own_cyc = own1 ? m1_cyc : m0_cyc;
  assign oth_cyc = own1 ? m0_cyc : m1_cyc;

  // Slave side: owner's request is forwarded, strobe gated when full
  assign s_cyc    = (own0 & m0_cyc) | (own1 & m1_cyc);
  assign s_stb    = ((own0 & m0_stb) | (own1 & m1_stb)) & ~full;
  assign s_we     = (own0 & m0_we) | (own1 & m1_we);
  assign s_addr   = own1 ? m1_addr   : m0_addr;
  assign s_data_w = own1 ? m1_data_w : m0_data_w;
  assign s_size   = own1 ? m1_size   : m0_size;

  // Master side: non-owners are held off, responses pass straight through
  assign m0_stall  = own0 ? (s_stall | full) : 1'b1;
  assign m1_stall  = own1 ? (s_stall | full) : 1'b1;
  assign m0_ack    = own0 & s_ack;
  assign m1_ack    = own1 & s_ack;
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_data_r = s_data_r;
  assign m1_data_r = s_data_r;
  assign grant     = grant_q;

  assign acc    = s_stb & ~s_stall;
  assign ret    = s_ack & (outst_q != 3'd0);
  assign tmo_nx = (s_ack | (outst_q == 3'd0)) ? 8'd0 : tmo_q + 8'd1;

  // Next-state: arbitration, release, outstanding and timeout tracking
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        outst_d = 3'd0;
        tmo_d   = 8'd0;
        if (m0_cyc & m1_cyc) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          state_d = GNT0;
        end else if (m1_cyc) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          if (oth_cyc) begin
            state_d = own1 ? GNT0 : GNT1;
          end else begin
            state_d = IDLE;
          end
          last_d  = own1;
          outst_d = 3'd0;
          tmo_d   = 8'd0;
        end else if (tmo_nx == TMO) begin
          state_d = ABORT;
          last_d  = own1;
          outst_d = 3'd0;
          tmo_d   = 8'd0;
        end else begin
          outst_d = outst_q + {2'b00, acc} - {2'b00, ret};
          tmo_d   = tmo_nx;
        end
      end
      ABORT: begin
        state_d = IDLE;
        outst_d = 3'd0;
        tmo_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered grant/error outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      outst_q <= 3'd0;
      tmo_q   <= 8'd0;
      grant_q <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      tmo_q   <= tmo_d;
      grant_q <= {state_d == GNT1, state_d == GNT0};
      err_q   <= (state_d == ABORT) ? {own1, own0} : 2'b00;
    end
  end

endmodule

// File: doc/leiwand_rv32_wb_arbiter.md
# leiwand_rv32_wb_arbiter

Two-master round-robin arbiter for the pipelined Wishbone bus that feeds the SoC's internal RAM and peripheral decode. It sits between the CPU core (master 0) and a second bus master such as a debug loader or DMA (master 1), and drives a single shared slave port. It holds each grant for the whole `cyc` burst, limits outstanding requests, and aborts a hung transfer with an error pulse after a timeout.

## Interface
- `MEM_WIDTH`, 32, address/data width
- `SIZE_WIDTH`, 3, width of the write-size field (bytes: 1, 2, 4)
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unacknowledged requests (1..7)
- `TIMEOUT`, 64, cycles without `s_ack` while requests are outstanding before abort (2..255)

- `CLK` in 1: system clock, rising edge
- `RST` in 1: asynchronous, active-high reset
- `m0_cyc`, `m0_stb`, `m0_we` in 1 each: master 0 bus cycle, strobe and write enable
- `m0_addr`, `m0_data_w` in MEM_WIDTH: master 0 address and write data
- `m0_size` in SIZE_WIDTH: master 0 write size
- `m0_data_r` out MEM_WIDTH: read data to master 0
- `m0_ack`, `m0_stall`, `m0_err` out 1 each: acknowledge, stall and error to master 0
- `m1_*`: identical set for master 1
- `s_cyc`, `s_stb`, `s_we` out 1 each: slave cycle, strobe and write enable
- `s_addr`, `s_data_w` out MEM_WIDTH: slave address and write data
- `s_size` out SIZE_WIDTH: slave write size
- `s_data_r` in MEM_WIDTH: read data from slave
- `s_ack`, `s_stall` in 1 each: slave acknowledge and stall
- `grant` out 2: one-hot current owner (00 = none)

## Operation
- States:
  - IDLE: no owner.
  - GNT0 / GNT1: the master owns the bus.
  - ABORT: one-cycle timeout termination.
- Arbitration happens only in IDLE or on release.
  - If only one `mN_cyc` is high, that master wins.
  - If both are high, the master not granted last wins. `last_grant` resets to 1, so master 0 wins the first tie.
- In GNTn:
  - `s_cyc`, `s_we`, `s_addr`, `s_data_w` and `s_size` are combinational copies of master n.
  - `s_stb = mn_stb & !full`.
  - `mn_stall = s_stall | full`.
  - `mn_ack = s_ack`.
  - `full` means `outstanding == MAX_OUTSTANDING`.
- The non-owner always sees `stall=1`, `ack=0` and `err=0`.
- In IDLE and ABORT, both masters see `stall=1`.
- `m0_data_r` and `m1_data_r` are both `s_data_r` (unqualified).
- Outstanding counter:
  - +1 on `s_stb & !s_stall`, −1 on `s_ack`; both in the same cycle leaves it unchanged.
  - `s_ack` with the counter at 0 is ignored; the counter saturates at 0.
  - Cleared on release, on ABORT and on reset.
- Release: owner drops `mn_cyc`.
  - Next state is GNT of the other master if its `cyc` is high, otherwise IDLE.
  - `last_grant` is set to the releasing master.
  - Dropping `cyc` with requests outstanding is a master violation. It still releases, and late acks are dropped.
- Timeout counter:
  - Increments each GNTn cycle with `outstanding != 0 & !s_ack`.
  - Cleared on `s_ack` or when `outstanding == 0`.
  - On reaching `TIMEOUT`, next state is ABORT.
- ABORT:
  - `s_cyc=0`, `s_stb=0`, `mn_err=1` for exactly one cycle to the aborted owner.
  - `s_ack` is ignored.
  - `last_grant` is set to the aborted master, then the state returns to IDLE.
- `RST` asserted at any time: immediately IDLE, counters 0, `last_grant=1`. Any in-flight transfer is abandoned without `err`.

## Timing
- Reset values:
  - `grant=00`
  - `s_cyc=s_stb=s_we=0`
  - `m0_stall=m1_stall=1`
  - all `ack`/`err` outputs 0
  - `s_addr`/`s_data_w`/`s_size` follow master 0 (don't-care while `s_cyc=0`)
- Grant latency: `mN_cyc` rises in cycle k, GNTn is registered at edge k+1, and `s_cyc` is high in cycle k+1.
- Handover: owner drops `cyc` in cycle k, the other master owns the bus in cycle k+1. There are zero idle cycles when the other is waiting.
- Ack, stall and read-data paths are combinational, with zero added latency.
- Abort timing: the `TIMEOUT`-th stalled cycle is followed by one ABORT cycle, then IDLE. Re-grant is no earlier than 2 cycles after ABORT.
- `grant` is registered and reflects the state.

## Test plan
- Reset: hold `RST=1` with both `cyc` high -> `grant=00`, `s_cyc=0`, both stalls 1. Release reset -> `grant=01` after 1 edge.
- Single master read: m0 `stb` at addr 0x0040_0004, slave acks 1 cycle later with 0xDEADBEEF -> `m0_ack=1` and `m0_data_r=0xDEADBEEF` in the same cycle; m1 sees `ack=0`, `stall=1`.
- Round-robin: both `cyc` held; m0 releases after 3 acks -> `grant=10` the next cycle. m1 releases -> `grant=01`. Simultaneous requests from IDLE after m0's last grant -> m1 wins.
- Outstanding limit: `MAX_OUTSTANDING=4`, slave never stalls and withholds ack -> 4 strobes accepted, then `m0_stall=1` and `s_stb=0`. One ack -> exactly one more strobe accepted.
- Timeout: `TIMEOUT=64`, 1 request accepted, no ack -> after 64 cycles, one ABORT cycle with `m0_err=1`, `s_cyc=0`, then IDLE. A waiting m1 is granted the cycle after.
- Mid-transfer reset: assert `RST` asynchronously during GNT1 with 2 outstanding -> `grant=00` and `s_cyc=0` before the next edge, with no `err` pulse.
